// File: rtl/tile_stat_if.sv
// Pixel/tile-cursor inputs and tile-result outputs of tile_stat, grouped as one bus.
// slave = the statistics block, master = whatever drives the pixel stream.
interface tile_stat_if;
    logic        vs_i;
    logic        de_i;
    logic [23:0] data_i;
    logic        v_save_i;
    logic [31:0] ht_cur_i;
    logic [31:0] vt_cur_i;
    logic        wr_en_o;
    logic [15:0] wr_addr_o;
    logic        wr_dark_o;
    logic        frame_done_o;
    logic        overrun_o;

    modport slave (
        input  vs_i, de_i, data_i, v_save_i, ht_cur_i, vt_cur_i,
        output wr_en_o, wr_addr_o, wr_dark_o, frame_done_o, overrun_o
    );
    modport master (
        output vs_i, de_i, data_i, v_save_i, ht_cur_i, vt_cur_i,
        input  wr_en_o, wr_addr_o, wr_dark_o, frame_done_o, overrun_o
    );
endinterface

// File: rtl/tile_stat.sv
// Per-tile luma accumulation and dark/not-dark classification, flushed one tile per cycle per row.
// Optional macro TILE_STAT_OVERRUN_EN: sticky flag for pixels arriving while a row is being flushed.
module tile_stat_lane (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        add_i,
    input  logic [9:0]  luma_i,
    output logic [31:0] acc_o,
    output logic [15:0] cnt_o
);
    logic [31:0] acc_q, acc_d;
    logic [15:0] cnt_q, cnt_d;

    // A clear in the same cycle as a pixel drops that pixel.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + 32'(luma_i);
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o = acc_q;
    assign cnt_o = cnt_q;
endmodule

module tile_stat #(
    parameter int HBLKS = 10,
    parameter int VBLKS = 10,
    parameter int THRES = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    tile_stat_if.slave bus
);
    localparam int IW = (HBLKS > 1) ? $clog2(HBLKS) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;
    typedef struct packed {
        logic [15:0] addr;
        logic        dark;
    } wr_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   row_q, row_d;
    logic          fl;
    logic [IW-1:0] fidx;
    logic [15:0]   frow;
    logic          wen_q, last_q, last_d, fd_q;
    wr_t           wr_q, wr_d;

    logic [9:0]               luma;
    logic                     ht_ok;
    logic [HBLKS-1:0][31:0]   acc_w;
    logic [HBLKS-1:0][15:0]   cnt_w;
    logic [31:0]              addr_full;
    logic                     unused_vt;

    assign luma  = {2'b0, bus.data_i[23:16]} + {1'b0, bus.data_i[15:8], 1'b0} + {2'b0, bus.data_i[7:0]};
    assign ht_ok = bus.ht_cur_i < 32'(HBLKS);
    assign unused_vt = ^bus.vt_cur_i[31:16];

    // Tile 0 is flushed in the same cycle v_save_i is seen so that tile i
    // appears on the write port exactly 1+i cycles later.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        fl      = 1'b0;
        fidx    = idx_q;
        frow    = row_q;
        unique case (state_q)
            IDLE: begin
                if (bus.v_save_i) begin
                    fl   = 1'b1;
                    fidx = '0;
                    frow = bus.vt_cur_i[15:0];
                end
            end
            FLUSH: fl = 1'b1;
            default: ;
        endcase
        if (fl) begin
            row_d = frow;
            if (fidx == IW'(HBLKS - 1)) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                state_d = FLUSH;
                idx_d   = fidx + IW'(1);
            end
        end
        if (bus.vs_i) begin
            state_d = IDLE;
            idx_d   = '0;
            fl      = 1'b0;
        end
    end

    genvar i;
    generate
        for (i = 0; i < HBLKS; i++) begin : g_lane
            tile_stat_lane u_lane (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .clr_i  (bus.vs_i || (fl && fidx == IW'(i))),
                .add_i  (bus.de_i && !bus.vs_i && ht_ok && bus.ht_cur_i == 32'(i)),
                .luma_i (luma),
                .acc_o  (acc_w[i]),
                .cnt_o  (cnt_w[i])
            );
        end
    endgenerate

    // cnt=0 gives a zero threshold product, so an empty tile is never dark.
    assign addr_full = 32'(frow) * 32'(HBLKS) + 32'(fidx);
    always_comb begin
        wr_d.addr = addr_full[15:0];
        wr_d.dark = 48'(acc_w[fidx]) < 48'(THRES) * 48'(cnt_w[fidx]);
        last_d    = fl && fidx == IW'(HBLKS - 1) && frow == 16'(VBLKS - 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            wen_q   <= 1'b0;
            wr_q    <= '0;
            last_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            wen_q   <= fl;
            if (fl) wr_q <= wr_d;
            last_q  <= last_d;
            fd_q    <= last_q;
        end
    end

`ifdef TILE_STAT_OVERRUN_EN
    logic ovr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovr_q <= 1'b0;
        else if (state_q == FLUSH && bus.de_i && !bus.vs_i) ovr_q <= 1'b1;
    end
    assign bus.overrun_o = ovr_q;
`else
    assign bus.overrun_o = 1'b0;
`endif

    assign bus.wr_en_o      = wen_q;
    assign bus.wr_addr_o    = wr_q.addr;
    assign bus.wr_dark_o    = wr_q.dark;
    assign bus.frame_done_o = fd_q;
endmodule

// File: tb/tb_tile_stat.sv
// Directed + random checks of tile_stat against a per-tile sum/count reference model.
module tb_tile_stat;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int TH = 256;
`ifdef TILE_STAT_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    tile_stat_if bus ();

    tile_stat #(.HBLKS(H), .VBLKS(V), .THRES(TH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Reference: running luma sum and pixel count per tile, plus a pending-flush cursor.
    longint    msum [H];
    int        mcnt [H];
    bit        mbusy;
    int        mi, mrow;
    bit        m_wen, m_dark, m_fd, m_ovr, m_final;
    logic [15:0] m_addr;

    function automatic logic [23:0] pix(input int l);
        int g, r;
        g = l / 4;
        r = l - 2 * g - g;
        return {8'(r), 8'(g), 8'(g)};
    endfunction

    task automatic model_reset();
        for (int t = 0; t < H; t++) begin msum[t] = 0; mcnt[t] = 0; end
        mbusy = 0; mi = 0; mrow = 0;
        m_wen = 0; m_dark = 0; m_fd = 0; m_ovr = 0; m_final = 0; m_addr = '0;
    endtask

    task automatic model_step(input bit vs, input bit de, input logic [23:0] d,
                              input bit vsave, input int unsigned ht, input int unsigned vt);
        bit was_busy;
        int ft, l;
        was_busy = mbusy;
        ft = -1;
        l = int'(d[23:16]) + 2 * int'(d[15:8]) + int'(d[7:0]);
        m_fd = m_final;
        if (vs) begin
            for (int t = 0; t < H; t++) begin msum[t] = 0; mcnt[t] = 0; end
            mbusy = 0;
            m_wen = 0;
        end else begin
            if (was_busy && de && OVR_EN) m_ovr = 1;
            if (!mbusy && vsave) begin mbusy = 1; mrow = int'(vt & 32'hFFFF); mi = 0; end
            if (mbusy) begin
                ft = mi;
                m_wen = 1;
                m_addr = 16'(mrow * H + mi);
                m_dark = (mcnt[mi] != 0) && (msum[mi] < longint'(TH) * mcnt[mi]);
                msum[mi] = 0; mcnt[mi] = 0;
                mi++;
                if (mi == H) mbusy = 0;
            end else begin
                m_wen = 0;
            end
            if (de && ht < H && int'(ht) != ft) begin
                msum[ht] += l;
                if (mcnt[ht] < 65535) mcnt[ht]++;
            end
        end
        m_final = m_wen && ft == H - 1 && mrow == V - 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wr_en"},      32'(bus.wr_en_o),      32'(m_wen));
        chk({tag, ".wr_addr"},    32'(bus.wr_addr_o),    32'(m_addr));
        chk({tag, ".wr_dark"},    32'(bus.wr_dark_o),    32'(m_dark));
        chk({tag, ".frame_done"}, 32'(bus.frame_done_o), 32'(m_fd));
        chk({tag, ".overrun"},    32'(bus.overrun_o),    32'(m_ovr));
    endtask

    task automatic step(input string tag, input bit vs, input bit de, input logic [23:0] d,
                        input bit vsave, input int unsigned ht, input int unsigned vt);
        bus.vs_i = vs; bus.de_i = de; bus.data_i = d;
        bus.v_save_i = vsave; bus.ht_cur_i = ht; bus.vt_cur_i = vt;
        @(posedge clk);
        #1;
        model_step(vs, de, d, vsave, ht, vt);
        check_all(tag);
    endtask

    task automatic feed(input int n, input int lum, input int unsigned ht);
        for (int p = 0; p < n; p++) step("feed", 0, 1, pix(lum), 0, ht, 0);
    endtask

    task automatic idle(input int n);
        for (int p = 0; p < n; p++) step("idle", 0, 0, 24'h0, 0, 0, 0);
    endtask

    initial begin
        bus.vs_i = 0; bus.de_i = 0; bus.data_i = '0;
        bus.v_save_i = 0; bus.ht_cur_i = '0; bus.vt_cur_i = '0;
        model_reset();
        #1;
        check_all("reset");
        #11 rst_ni = 1'b1;

        // Tile 2 of row 3 gets 900 pixels of luma 100; other tiles stay empty.
        feed(900, 100, 2);
        step("r3_k", 0, 0, 24'h0, 1, 0, 3);
        chk("r3_addr12", 32'(bus.wr_addr_o), 32'd12);
        chk("r3_dark12", 32'(bus.wr_dark_o), 32'd0);
        idle(1);
        chk("r3_addr13", 32'(bus.wr_addr_o), 32'd13);
        idle(1);
        chk("r3_addr14", 32'(bus.wr_addr_o), 32'd14);
        chk("r3_dark14", 32'(bus.wr_dark_o), 32'd1);
        idle(1);
        chk("r3_addr15", 32'(bus.wr_addr_o), 32'd15);
        chk("r3_dark15", 32'(bus.wr_dark_o), 32'd0);
        idle(1);
        chk("r3_wen_off", 32'(bus.wr_en_o), 32'd0);
        chk("r3_no_fd", 32'(bus.frame_done_o), 32'd0);

        // Threshold boundary on tile 0: luma 300 is bright, luma 255 is dark.
        feed(900, 300, 0);
        step("t300_k", 0, 0, 24'h0, 1, 0, 0);
        chk("t300_dark", 32'(bus.wr_dark_o), 32'd0);
        idle(4);
        feed(900, 255, 0);
        step("t255_k", 0, 0, 24'h0, 1, 0, 0);
        chk("t255_dark", 32'(bus.wr_dark_o), 32'd1);
        idle(3);
        chk("row0_no_fd_a", 32'(bus.wr_en_o), 32'd1);
        idle(1);
        chk("row0_no_fd", 32'(bus.frame_done_o), 32'd0);

        // Last row flush raises frame_done_o exactly once at k+H+1.
        step("r1_k", 0, 0, 24'h0, 1, 0, 1);
        idle(3);
        chk("r1_last_addr", 32'(bus.wr_addr_o), 32'd7);
        chk("r1_fd_early", 32'(bus.frame_done_o), 32'd0);
        idle(1);
        chk("r1_fd_pulse", 32'(bus.frame_done_o), 32'd1);
        chk("r1_fd_wen", 32'(bus.wr_en_o), 32'd0);
        idle(1);
        chk("r1_fd_once", 32'(bus.frame_done_o), 32'd0);

        // Pixel during flush: sticky overrun only with the feature built in.
        step("ov_k", 0, 0, 24'h0, 1, 0, 0);
        idle(1);
        step("ov_k2", 0, 1, pix(50), 0, 1, 0);
        chk("ov_set", 32'(bus.overrun_o), 32'(OVR_EN));
        idle(2);
        step("ov_vs", 1, 0, 24'h0, 0, 0, 0);
        chk("ov_after_vs", 32'(bus.overrun_o), 32'(OVR_EN));

        // vs_i mid-flush aborts writes and empties the accumulators.
        feed(10, 1020, 3);
        step("vs_k", 0, 0, 24'h0, 1, 0, 1);
        idle(1);
        step("vs_k2", 1, 1, pix(1020), 1, 3, 1);
        chk("vs_wen_off", 32'(bus.wr_en_o), 32'd0);
        idle(1);
        chk("vs_wen_stay", 32'(bus.wr_en_o), 32'd0);
        feed(1, 100, 3);
        step("vs_refl", 0, 0, 24'h0, 1, 0, 0);
        idle(3);
        chk("vs_t3_fresh", 32'(bus.wr_dark_o), 32'd1);
        idle(2);

        // Asynchronous reset mid-flush clears every output without a clock edge.
        feed(5, 40, 1);
        step("rst_k", 0, 0, 24'h0, 1, 0, 1);
        idle(1);
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("rst_wen", 32'(bus.wr_en_o), 32'd0);
        chk("rst_addr", 32'(bus.wr_addr_o), 32'd0);
        chk("rst_dark", 32'(bus.wr_dark_o), 32'd0);
        chk("rst_fd", 32'(bus.frame_done_o), 32'd0);
        chk("rst_ovr", 32'(bus.overrun_o), 32'd0);
        #2 rst_ni = 1'b1;
        idle(3);
        chk("rst_no_resume", 32'(bus.wr_en_o), 32'd0);

        // Random traffic, including out-of-range tiles and v_save_i during flush.
        for (int c = 0; c < 600; c++) begin
            int unsigned r;
            int unsigned ht;
            r  = $urandom_range(0, 5);
            ht = (r == 5) ? 32'hFFFF_FFF0 : r;
            step("rand", $urandom_range(0, 99) == 0, ($urandom % 3) != 0, 24'($urandom),
                 $urandom_range(0, 9) == 0, ht, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/tile_stat.md
TILE_STAT -- requirements
Module: tile_stat

Interface
REQ-001 SHALL have parameter HBLKS, default 10, tiles per row.
REQ-002 SHALL have parameter VBLKS, default 10, tile rows per frame.
REQ-003 SHALL have parameter THRES, default 256, per-pixel luma threshold (luma range 0..1020).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port vs_i  input  1  vertical sync, frame restart.
REQ-007 SHALL have port de_i  input  1  pixel valid.
REQ-008 SHALL have port data_i  input  24  pixel, R[23:16] G[15:8] B[7:0].
REQ-009 SHALL have port v_save_i  input  1  tile-row end pulse from the tile cursor.
REQ-010 SHALL have port ht_cur_i  input  32  horizontal tile index from the tile cursor.
REQ-011 SHALL have port vt_cur_i  input  32  vertical tile index from the tile cursor.
REQ-012 SHALL have port wr_en_o  output  1  tile-result write strobe.
REQ-013 SHALL have port wr_addr_o  output  16  tile address, vt*HBLKS+ht.
REQ-014 SHALL have port wr_dark_o  output  1  1 = tile is dark.
REQ-015 SHALL have port frame_done_o  output  1  one-cycle pulse after last tile of frame is written.
REQ-016 SHALL have port overrun_o  output  1  sticky flush-overrun flag.

Function
REQ-017 SHALL compute luma = R + 2*G + B (10 bits, no truncation).
REQ-018 SHALL keep HBLKS accumulators acc[i] (32 bits) and pixel counters cnt[i] (16 bits, saturating at 65535).
REQ-019 SHALL, on each cycle with de_i=1 and ht_cur_i<HBLKS, add luma to acc[ht_cur_i] and increment cnt[ht_cur_i]; ht_cur_i>=HBLKS SHALL be ignored.
REQ-020 SHALL implement states IDLE and FLUSH; IDLE->FLUSH on v_save_i=1, latching row = vt_cur_i[15:0] and index i=0.
REQ-021 SHALL, in FLUSH, each cycle register wr_en_o=1, wr_addr_o=row*HBLKS+i (mod 2^16), wr_dark_o=(acc[i] < THRES*cnt[i]), then clear acc[i] and cnt[i] and increment i.
REQ-022 SHALL make the write for tile i appear at cycle k+1+i after v_save_i at cycle k; FLUSH->IDLE after i=HBLKS-1.
REQ-023 SHALL treat a tile with cnt=0 as not dark.
REQ-024 SHALL pulse frame_done_o one cycle, coincident with wr_en_o deasserting, when the flushed row equals VBLKS-1.
REQ-025 SHALL, when de_i=1 for tile index j in the same cycle acc[j] is cleared by flush, let the clear win (pixel dropped).
REQ-026 SHALL ignore v_save_i while in FLUSH.
REQ-027 SHALL, on vs_i=1, clear all acc/cnt, force IDLE, and deassert wr_en_o next cycle; vs_i has priority over v_save_i and de_i; overrun_o is not cleared.
REQ-028 SHALL hold wr_en_o=0 and frame_done_o=0 outside the cycles defined above; wr_addr_o/wr_dark_o hold last value.

Reset
REQ-029 SHALL, while rst_ni=0, force IDLE, acc/cnt=0, wr_en_o=0, wr_addr_o=0, wr_dark_o=0, frame_done_o=0, overrun_o=0.
REQ-030 SHALL, on reset mid-FLUSH, abandon remaining writes; first write after release needs a new v_save_i.

Configuration
REQ-031 SHALL, with TILE_STAT_OVERRUN_EN defined, set overrun_o=1 when de_i=1 while in FLUSH, held until reset.
REQ-032 SHALL, without TILE_STAT_OVERRUN_EN, tie overrun_o to 0 and contain no detection logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: HBLKS=4, tile 2 fed 900 pixels luma 100, v_save_i at row 3 -> writes addr 12..15 at k+1..k+4, addr 14 dark=1, others dark=0 (cnt=0).
REQ-034 SHALL cover: tile 0 fed 900 pixels luma 300, THRES=256 -> dark=0; luma 255 -> dark=1.
REQ-035 SHALL cover: VBLKS=2, flush of row 1 -> frame_done_o pulses once at k+HBLKS+1; row 0 -> no pulse.
REQ-036 SHALL cover: de_i=1 at k+2 during flush with macro -> overrun_o=1 and stays 1 through vs_i; without macro -> overrun_o=0.
REQ-037 SHALL cover: vs_i at k+2 mid-flush -> wr_en_o=0 from k+3, next row's accumulators start from 0; rst_ni low mid-flush -> all outputs 0 immediately.
